// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, ZF/SF/OF condition codes and the M pipeline register.
// Optional macro EXEC_PERF_CNT_EN adds perf_insn / perf_mispred counters.
module execute_stage #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   E_stat,
  input  logic [3:0]   E_icode,
  input  logic [3:0]   E_ifun,
  input  logic [W-1:0] E_valA,
  input  logic [W-1:0] E_valB,
  input  logic [W-1:0] E_valC,
  input  logic [3:0]   E_dstE,
  input  logic [3:0]   E_dstM,
  input  logic [1:0]   m_stat,
  input  logic [1:0]   W_stat,
  input  logic         M_bubble,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_cnd,
  output logic [1:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic [3:0]   M_ifun,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]  perf_insn,
  output logic [31:0]  perf_mispred
`endif
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] A_ADD    = 4'h0;
  localparam logic [3:0] A_SUB    = 4'h1;
  localparam logic [3:0] A_AND    = 4'h2;
  localparam logic [3:0] A_XOR    = 4'h3;

  localparam logic [W-1:0] POS_EIGHT = {{(W-4){1'b0}}, 4'h8};
  localparam logic [W-1:0] NEG_EIGHT = ~POS_EIGHT + {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] alu_a_s;
  logic [W-1:0] alu_b_s;
  logic [3:0]   alu_fun_s;
  logic [W-1:0] alu_out_s;
  logic         of_new_s;
  logic         zf_new_s;
  logic         sf_new_s;
  logic         set_cc_s;
  logic         cnd_raw_s;
  logic         zf_r;
  logic         sf_r;
  logic         of_r;

  // ALU operand A selection
  always_comb begin
    alu_a_s = '0;
    case (E_icode)
      I_RRMOV, I_OPQ:            alu_a_s = E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a_s = E_valC;
      I_CALL, I_PUSH:            alu_a_s = NEG_EIGHT;
      I_RET, I_POP:              alu_a_s = POS_EIGHT;
      default:                   alu_a_s = '0;
    endcase
  end

  // ALU operand B selection
  always_comb begin
    alu_b_s = '0;
    case (E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b_s = E_valB;
      default:                                               alu_b_s = '0;
    endcase
  end

  assign alu_fun_s = (E_icode == I_OPQ) ? E_ifun : A_ADD;

  // ALU result and overflow flag
  always_comb begin
    alu_out_s = '0;
    of_new_s  = 1'b0;
    case (alu_fun_s)
      A_ADD: begin
        alu_out_s = alu_b_s + alu_a_s;
        of_new_s  = (alu_a_s[W-1] == alu_b_s[W-1]) && (alu_out_s[W-1] != alu_a_s[W-1]);
      end
      A_SUB: begin
        alu_out_s = alu_b_s - alu_a_s;
        of_new_s  = (alu_a_s[W-1] != alu_b_s[W-1]) && (alu_out_s[W-1] != alu_b_s[W-1]);
      end
      A_AND:   alu_out_s = alu_b_s & alu_a_s;
      A_XOR:   alu_out_s = alu_b_s ^ alu_a_s;
      default: alu_out_s = '0;
    endcase
  end

  assign zf_new_s = (alu_out_s == '0);
  assign sf_new_s = alu_out_s[W-1];
  assign e_valE   = alu_out_s;

  // CC writes are suppressed once an older stage has faulted, so an exception leaves state intact
  assign set_cc_s = (E_icode == I_OPQ) && (E_stat == STAT_AOK) &&
                    (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Condition evaluation against the current CC, gated to cmov/jXX
  always_comb begin
    cnd_raw_s = 1'b0;
    e_cnd     = 1'b0;
    case (E_ifun)
      4'h0:    cnd_raw_s = 1'b1;
      4'h1:    cnd_raw_s = (sf_r ^ of_r) | zf_r;
      4'h2:    cnd_raw_s = sf_r ^ of_r;
      4'h3:    cnd_raw_s = zf_r;
      4'h4:    cnd_raw_s = ~zf_r;
      4'h5:    cnd_raw_s = ~(sf_r ^ of_r);
      4'h6:    cnd_raw_s = ~(sf_r ^ of_r) & ~zf_r;
      default: cnd_raw_s = 1'b0;
    endcase
    if ((E_icode == I_RRMOV) || (E_icode == I_JXX)) begin
      e_cnd = cnd_raw_s;
    end else begin
      e_cnd = 1'b0;
    end
  end

  // Untaken cmov cancels its register write
  always_comb begin
    e_dstE = E_dstE;
    if ((E_icode == I_RRMOV) && !e_cnd) begin
      e_dstE = RNONE;
    end else begin
      e_dstE = E_dstE;
    end
  end

  // Condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_r <= 1'b1;
      sf_r <= 1'b0;
      of_r <= 1'b0;
    end else if (set_cc_s && !M_bubble) begin
      zf_r <= zf_new_s;
      sf_r <= sf_new_s;
      of_r <= of_new_s;
    end
  end

  // M pipeline register; reset and bubble both load a nop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_ifun  <= 4'h0;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else if (M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_ifun  <= 4'h0;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_ifun  <= E_ifun;
      M_cnd   <= e_cnd;
      M_valE  <= e_valE;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  // Instruction and not-taken-jump counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_insn    <= 32'd0;
      perf_mispred <= 32'd0;
    end else if (!M_bubble) begin
      if (E_icode != I_NOP) begin
        perf_insn <= perf_insn + 32'd1;
      end
      if ((E_icode == I_JXX) && !e_cnd) begin
        perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end
`endif

endmodule
